// File: rtl/sr_latch_bank.sv
// sr_latch_bank: WIDTH-channel clocked SR flag bank with per-channel conflict flags and a saturating conflict counter.
// Latency: S/R/E to Q is 1 cycle, or 3 cycles with SR_LATCH_BANK_SYNC_EN defined (2-flop input synchronisers); Q_Inverter is combinational.
// Backpressure: none; E=0 freezes the bank, and the bank accepts every enabled edge.
module sr_latch_bank #(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}},
  parameter int               CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 E,
  input  logic [WIDTH-1:0]     S,
  input  logic [WIDTH-1:0]     R,
  input  logic                 Clear_Conflict,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     Q_Inverter,
  output logic [WIDTH-1:0]     Changed,
  output logic [WIDTH-1:0]     Conflict,
  output logic [CNT_WIDTH-1:0] Conflict_Count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic             e_eff;
  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] r_eff;

`ifdef SR_LATCH_BANK_SYNC_EN
  logic [1:0]       e_sync;
  logic [WIDTH-1:0] s_sync1, s_sync2;
  logic [WIDTH-1:0] r_sync1, r_sync2;

  // Clear_Conflict deliberately bypasses the synchronisers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_sync  <= 2'b00;
      s_sync1 <= '0;
      s_sync2 <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      e_sync  <= {e_sync[0], E};
      s_sync1 <= S;
      s_sync2 <= s_sync1;
      r_sync1 <= R;
      r_sync2 <= r_sync1;
    end
  end

  assign e_eff = e_sync[1];
  assign s_eff = s_sync2;
  assign r_eff = r_sync2;
`else
  assign e_eff = E;
  assign s_eff = S;
  assign r_eff = R;
`endif

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] conf_hit;
  logic             any_conf;

  always_comb begin
    q_nxt    = Q;
    conf_hit = '0;
    if (e_eff) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({s_eff[i], r_eff[i]})
          2'b10: q_nxt[i] = 1'b1;
          2'b01: q_nxt[i] = 1'b0;
          2'b11: begin
            conf_hit[i] = 1'b1;
            // Unlisted mode values fall back to hold.
            case (CONFLICT_MODE)
              1:       q_nxt[i] = 1'b1;
              2:       q_nxt[i] = 1'b0;
              3:       q_nxt[i] = ~Q[i];
              default: q_nxt[i] = Q[i];
            endcase
          end
          default: q_nxt[i] = Q[i];
        endcase
      end
    end
  end

  assign any_conf = |conf_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q              <= RESET_VALUE;
      Changed        <= '0;
      Conflict       <= '0;
      Conflict_Count <= '0;
    end else begin
      Q       <= q_nxt;
      Changed <= q_nxt ^ Q;
      // A conflict in the same cycle as a clear survives the clear.
      Conflict <= (Clear_Conflict ? '0 : Conflict) | conf_hit;
      if (Clear_Conflict)
        Conflict_Count <= any_conf ? CNT_WIDTH'(1) : '0;
      else if (any_conf && (Conflict_Count != CNT_MAX))
        Conflict_Count <= Conflict_Count + CNT_WIDTH'(1);
    end
  end

  assign Q_Inverter = ~Q;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Bench for sr_latch_bank: four instances (CONFLICT_MODE 0..3) share one stimulus stream.
// The bench checks directed spec cases and randomized traffic against a per-channel reference model.
module tb_sr_latch_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e;
  logic [7:0] s, r;
  logic       clr;

  logic [7:0] q_o   [4];
  logic [7:0] qi_o  [4];
  logic [7:0] chg_o [4];
  logic [7:0] conf_o[4];
  logic [7:0] cnt_o [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sr_latch_bank #(
      .WIDTH(8), .CONFLICT_MODE(g), .RESET_VALUE(8'h00), .CNT_WIDTH(8)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .E(e), .S(s), .R(r), .Clear_Conflict(clr),
      .Q(q_o[g]), .Q_Inverter(qi_o[g]), .Changed(chg_o[g]),
      .Conflict(conf_o[g]), .Conflict_Count(cnt_o[g])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state, one Q/Changed per conflict mode; conflict logging is mode-independent.
  logic [7:0] m_q[4];
  logic [7:0] m_chg[4];
  logic [7:0] m_conf;
  int         m_cnt;
  logic       p1_e, p2_e;
  logic [7:0] p1_s, p2_s, p1_r, p2_r;

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      m_q[m]   = 8'h00;
      m_chg[m] = 8'h00;
    end
    m_conf = 8'h00;
    m_cnt  = 0;
    p1_e = 0; p2_e = 0; p1_s = 0; p2_s = 0; p1_r = 0; p2_r = 0;
  endtask

  task automatic model_edge();
    logic       ee, any;
    logic [7:0] es, er, old, nq;
`ifdef SR_LATCH_BANK_SYNC_EN
    ee = p2_e; es = p2_s; er = p2_r;
    p2_e = p1_e; p2_s = p1_s; p2_r = p1_r;
    p1_e = e; p1_s = s; p1_r = r;
`else
    ee = e; es = s; er = r;
`endif
    any = ee && ((es & er) != 8'h00);
    for (int m = 0; m < 4; m++) begin
      old = m_q[m];
      nq  = old;
      if (ee) begin
        for (int i = 0; i < 8; i++) begin
          if (es[i] && !er[i])      nq[i] = 1'b1;
          else if (!es[i] && er[i]) nq[i] = 1'b0;
          else if (es[i] && er[i])
            nq[i] = (m == 1) ? 1'b1 : (m == 2) ? 1'b0 : (m == 3) ? ~old[i] : old[i];
        end
      end
      m_chg[m] = nq ^ old;
      m_q[m]   = nq;
    end
    if (clr) m_conf = 8'h00;
    if (ee)  m_conf = m_conf | (es & er);
    if (clr)                        m_cnt = any ? 1 : 0;
    else if (any && (m_cnt < 255))  m_cnt = m_cnt + 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    e = 1'b0; s = 8'hFF; r = 8'hFF; clr = 1'b0;
    repeat (3) step();
    for (int m = 0; m < 4; m++) begin
      n_checks++;
      if (q_o[m] !== 8'h00) $display("FAIL reset_q mode%0d: got %h want 00", m, q_o[m]);
      else n_pass++;
      n_checks++;
      if (qi_o[m] !== 8'hFF) $display("FAIL reset_qinv mode%0d: got %h want ff", m, qi_o[m]);
      else n_pass++;
      n_checks++;
      if ({chg_o[m], conf_o[m], cnt_o[m]} !== 24'h0)
        $display("FAIL reset_flags mode%0d: got chg=%h conf=%h cnt=%0d want 0", m, chg_o[m], conf_o[m], cnt_o[m]);
      else n_pass++;
    end
  endtask

  task automatic test_set_reset();
    logic [7:0] exp_q[3]   = '{8'h0F, 8'h0C, 8'h0C};
    logic [7:0] exp_chg[3] = '{8'h0F, 8'h03, 8'h00};
    for (int k = 0; k < 3; k++) begin
      e = 1'b1;
      s = (k == 0) ? 8'h0F : 8'h00;
      r = (k == 0) ? 8'h00 : 8'h03;
      step();
      for (int m = 0; m < 4; m++) begin
        n_checks++;
        if (q_o[m] !== exp_q[k]) $display("FAIL setreset_q step%0d mode%0d: got %h want %h", k, m, q_o[m], exp_q[k]);
        else n_pass++;
        n_checks++;
        if (chg_o[m] !== exp_chg[k]) $display("FAIL setreset_chg step%0d mode%0d: got %h want %h", k, m, chg_o[m], exp_chg[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_conflict_modes();
    logic [7:0] exp_q[4] = '{8'h0C, 8'h0D, 8'h08, 8'h09};
    e = 1'b1; s = 8'h05; r = 8'h05;
    step();
    for (int m = 0; m < 4; m++) begin
      n_checks++;
      if (q_o[m] !== exp_q[m]) $display("FAIL mode_q mode%0d: got %h want %h", m, q_o[m], exp_q[m]);
      else n_pass++;
      n_checks++;
      if (conf_o[m] !== 8'h05) $display("FAIL mode_conflict mode%0d: got %h want 05", m, conf_o[m]);
      else n_pass++;
      n_checks++;
      if (cnt_o[m] !== 8'd1) $display("FAIL mode_count mode%0d: got %0d want 1", m, cnt_o[m]);
      else n_pass++;
    end
  endtask

  task automatic test_clear_race();
    e = 1'b1; s = 8'h80; r = 8'h80; clr = 1'b0;
    step();
    s = 8'h01; r = 8'h01; clr = 1'b1;
    step();
    for (int m = 0; m < 4; m++) begin
      n_checks++;
      if ({conf_o[m], cnt_o[m]} !== {8'h01, 8'd1})
        $display("FAIL race_clear_conflict mode%0d: got conf=%h cnt=%0d want 01/1", m, conf_o[m], cnt_o[m]);
      else n_pass++;
    end
    s = 8'h00; r = 8'h00;
    step();
    for (int m = 0; m < 4; m++) begin
      n_checks++;
      if ({conf_o[m], cnt_o[m]} !== 16'h0)
        $display("FAIL race_clear_only mode%0d: got conf=%h cnt=%0d want 0/0", m, conf_o[m], cnt_o[m]);
      else n_pass++;
    end
    clr = 1'b0;
  endtask

`ifdef SR_LATCH_BANK_SYNC_EN
  task automatic test_sync_latency();
    logic [2:0] exp_q7 = 3'b100;
    e = 1'b1; s = 8'h80; r = 8'h00; clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (q_o[0][7] !== exp_q7[k]) $display("FAIL sync_latency edge+%0d: got %b want %b", k, q_o[0][7], exp_q7[k]);
      else n_pass++;
    end
    s = 8'h00;
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      e   = ($urandom_range(0, 7) != 0);
      s   = 8'($urandom);
      r   = 8'($urandom) & 8'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      step();
      for (int m = 0; m < 4; m++) begin
        n_checks++;
        if (q_o[m] !== m_q[m]) $display("FAIL rand_q cyc%0d mode%0d: got %h want %h", n, m, q_o[m], m_q[m]);
        else n_pass++;
        n_checks++;
        if (qi_o[m] !== ~m_q[m]) $display("FAIL rand_qinv cyc%0d mode%0d: got %h want %h", n, m, qi_o[m], ~m_q[m]);
        else n_pass++;
        n_checks++;
        if (chg_o[m] !== m_chg[m]) $display("FAIL rand_changed cyc%0d mode%0d: got %h want %h", n, m, chg_o[m], m_chg[m]);
        else n_pass++;
        n_checks++;
        if (conf_o[m] !== m_conf) $display("FAIL rand_conflict cyc%0d mode%0d: got %h want %h", n, m, conf_o[m], m_conf);
        else n_pass++;
        n_checks++;
        if (cnt_o[m] !== 8'(m_cnt)) $display("FAIL rand_count cyc%0d mode%0d: got %0d want %0d", n, m, cnt_o[m], m_cnt);
        else n_pass++;
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_saturation();
    e = 1'b1; s = 8'h00; r = 8'h00; clr = 1'b1;
    step();
    clr = 1'b0; s = 8'h01; r = 8'h01;
    repeat (300) step();
    for (int m = 0; m < 4; m++) begin
      n_checks++;
      if (cnt_o[m] !== 8'd255) $display("FAIL sat_count mode%0d: got %0d want 255", m, cnt_o[m]);
      else n_pass++;
      n_checks++;
      if (conf_o[m] !== m_conf) $display("FAIL sat_conflict mode%0d: got %h want %h", m, conf_o[m], m_conf);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    // Two cycles mid-run with ones in Q, then reset between edges.
    e = 1'b1; s = 8'hA5; r = 8'h00;
    step();
    s = 8'h01; r = 8'h01;
    step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 4; m++) begin
      n_checks++;
      if ({q_o[m], qi_o[m], chg_o[m], conf_o[m], cnt_o[m]} !== {8'h00, 8'hFF, 8'h00, 8'h00, 8'h00})
        $display("FAIL async_reset mode%0d: got q=%h qi=%h chg=%h conf=%h cnt=%0d want 00/ff/00/00/0",
                 m, q_o[m], qi_o[m], chg_o[m], conf_o[m], cnt_o[m]);
      else n_pass++;
    end
    #2 rst_n = 1'b1;
    e = 1'b0;
    step();
    for (int m = 0; m < 4; m++) begin
      n_checks++;
      if ({q_o[m], cnt_o[m]} !== 16'h0) $display("FAIL post_reset_hold mode%0d: got q=%h cnt=%0d want 00/0", m, q_o[m], cnt_o[m]);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; e = 1'b0; s = 8'h00; r = 8'h00; clr = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    test_reset();
`ifdef SR_LATCH_BANK_SYNC_EN
    test_sync_latency();
`else
    test_set_reset();
    test_conflict_modes();
    test_clear_race();
`endif
    test_random();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_latch_bank.md
Name: sr_latch_bank

Overview:
- Parametrised, clocked multi-channel SR storage bank; successor to the single-bit enabled SR latch.
- WIDTH independent SR channels share one enable.
- Each channel has a selectable S=R=1 conflict resolution mode, per-channel change pulses, sticky conflict flags and a saturating conflict-event counter.
- Used as a status/flag register bank wherever set/clear event pairs must be captured synchronously.

Parameters:
- WIDTH, 8, number of SR channels (1..32).
- CONFLICT_MODE, 0, S=R=1 resolution: 0 hold, 1 set wins, 2 reset wins, 3 toggle; any other value behaves as 0.
- RESET_VALUE, {WIDTH{1'b0}}, per-channel value loaded into Q on reset.
- CNT_WIDTH, 8, width of Conflict_Count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- E  input  1  enable; when 0 the whole bank holds.
- S  input  WIDTH  per-channel set.
- R  input  WIDTH  per-channel reset.
- Clear_Conflict  input  1  synchronous clear of Conflict and Conflict_Count.
- Q  output  WIDTH  registered channel state.
- Q_Inverter  output  WIDTH  bitwise complement of Q.
- Changed  output  WIDTH  registered one-cycle pulse per channel whose Q changed.
- Conflict  output  WIDTH  sticky per-channel S=R=1 flag.
- Conflict_Count  output  CNT_WIDTH  saturating count of conflict cycles.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - Q=RESET_VALUE; Changed=0; Conflict=0; Conflict_Count=0.
  - Q_Inverter=~RESET_VALUE immediately.
  - Deassertion takes effect on the next rising edge.
- Latency: S/R/E sampled at rising edge; Q updates at that edge (1 cycle). Q_Inverter is combinational ~Q, never equal to Q.
- Per channel i at each edge with E=1:
  - S=1,R=0: Q[i]<=1.
  - S=0,R=1: Q[i]<=0.
  - S=0,R=0: hold.
  - S=1,R=1: apply CONFLICT_MODE (0 hold, 1 ->1, 2 ->0, 3 ->~Q[i]).
- E=0: Q holds regardless of S/R. No conflict logging. Changed<=0.
- Changed[i]<=1 on an edge exactly when the new Q[i] differs from the old Q[i], else 0. Set on an already-set channel gives no pulse.
- Conflict[i]:
  - Set on an edge with E=1 and S[i]=R[i]=1.
  - Cleared on an edge with Clear_Conflict=1.
  - Simultaneous clear and new conflict: the bit ends 1; new conflict wins.
- Conflict_Count:
  - +1 on each edge with E=1 and any channel S&R=1; one increment per cycle regardless of how many channels conflict.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
  - Clear_Conflict=1 loads 0, or 1 if a conflict occurs that same cycle.
- Conflict logging is independent of CONFLICT_MODE (mode 1/2/3 still flag).

Optional Feature:
- Macro SR_LATCH_BANK_SYNC_EN.
- Defined:
  - S, R and E each pass through a 2-flop synchroniser clocked by clk and reset to 0 by rst_n.
  - Input-to-Q latency becomes 3 cycles.
  - Changed, Conflict and Conflict_Count act on the synchronised values.
  - Clear_Conflict is not synchronised.
- Undefined: inputs used directly; latency 1 cycle.

Test Plan (WIDTH=8, RESET_VALUE=8'h00, CNT_WIDTH=8, macro undefined unless stated):
- Reset/hold: rst_n=0 then 1; E=0, S=8'hFF, R=8'hFF for 3 cycles -> Q=8'h00, Q_Inverter=8'hFF, Changed=0, Conflict=0, Conflict_Count=0.
- Set/reset with pulses: E=1, S=8'h0F, R=0 one cycle -> Q=8'h0F, Changed=8'h0F for one cycle. Then S=0, R=8'h03 -> Q=8'h0C, Changed=8'h03. Repeat R=8'h03 -> Changed=0.
- Conflict modes: Q=8'h0C; E=1, S=R=8'h05:
  - Mode 0 -> Q=8'h0C.
  - Mode 1 -> 8'h0D.
  - Mode 2 -> 8'h08.
  - Mode 3 -> 8'h09.
  - All modes -> Conflict=8'h05, Conflict_Count=1.
- Sticky/clear race: conflict on bit 7, then Clear_Conflict=1 with new S=R=8'h01 same cycle -> Conflict=8'h01, Conflict_Count=1. Next cycle Clear_Conflict=1, no conflict -> Conflict=0, count=0.
- Saturation: S=R=8'h01, E=1 for 300 cycles -> Conflict_Count=255 and holds. Async rst_n pulse mid-run, off clock edge -> all outputs to reset values immediately.
- SR_LATCH_BANK_SYNC_EN defined: E=1, S=8'h80 at edge n -> Q[7]=1 at edge n+2 registered output (3-cycle latency), not earlier.
